// File: rtl/icache_assoc_fill_pkg.sv
// Shared types for the set-associative instruction cache with multi-word line fill.
package icache_assoc_fill_pkg;

  typedef logic [31:0] word_t;

  // Controller state, also exported on the fsm_state debug port.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Width of the fill word counter. It is at least one bit so that a
  // one-word line (IBLK_W == 0) still has a legal counter.
  function automatic int cnt_width(input int blk_w);
    return (blk_w > 0) ? blk_w : 1;
  endfunction

endpackage

// File: rtl/icache_assoc_fill_way.sv
// One cache way: SETS frames (valid, tag, line words), with tag compare, word
// select on the lookup port and a fill write port that also commits the tag.
module icache_assoc_fill_way
  import icache_assoc_fill_pkg::*;
#(
  parameter int IIDX_W = 4,
  parameter int IBLK_W = 1,
  parameter int ITAG_W = 25,
  parameter int CNT_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IIDX_W-1:0] rd_idx,
  input  logic [ITAG_W-1:0] rd_tag,
  input  logic [CNT_W-1:0]  rd_blk,
  output logic              hit,
  output logic              valid,
  output word_t             rd_word,
  input  logic              wr_en,
  input  logic [IIDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0]  wr_blk,
  input  word_t             wr_data,
  input  logic              commit,
  input  logic [ITAG_W-1:0] commit_tag
);

  localparam int SETS = 1 << IIDX_W;
  localparam int WPB  = 1 << IBLK_W;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t [WPB-1:0]   words;
  } frame_t;

  frame_t frames [SETS];
  frame_t rd_frame;

  // Lookup: read the indexed frame, compare its tag and pick the word.
  always_comb begin
    rd_frame = frames[rd_idx];
    valid    = rd_frame.valid;
    hit      = rd_frame.valid && (rd_frame.tag == rd_tag);
    rd_word  = rd_frame.words[rd_blk];
  end

  // Frame storage: flush drops every valid bit; fill writes one word per
  // accepted beat, and the commit on the final beat validates the line.
  // A line being overwritten keeps its old valid/tag until commit; that is
  // harmless because lookups are masked while a fill is in flight and an
  // aborted fill only happens on flush or reset, which clear the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) frames[s] <= '0;
    end else begin
      if (flush) begin
        for (int s = 0; s < SETS; s++) frames[s].valid <= 1'b0;
      end
      if (wr_en) frames[wr_idx].words[wr_blk] <= wr_data;
      if (commit) begin
        frames[wr_idx].valid <= 1'b1;
        frames[wr_idx].tag   <= commit_tag;
      end
    end
  end

endmodule

// File: rtl/icache_assoc_fill.sv
// Set-associative (1 or 2 way) instruction cache with LRU replacement,
// sequential multi-word line fill, single-cycle flush and hit/miss counters.
//
// Memory handshake: while iREN=1 the cache holds iaddr steady; a word is
// transferred on every rising edge where iREN=1 and iwait=0, after which
// iaddr advances to the next word of the line. iREN never drops mid-line
// except on flush or reset.
module icache_assoc_fill
  import icache_assoc_fill_pkg::*;
#(
  parameter int IIDX_W = 4,
  parameter int IBLK_W = 1,
  parameter int WAYS   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          imemREN,
  input  logic [31:0]   imemaddr,
  output logic          ihit,
  output word_t         imemload,
  input  logic          flush,
  output logic          iREN,
  output logic [31:0]   iaddr,
  input  logic          iwait,
  input  word_t         iload,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count,
  output icache_state_t fsm_state
);

  localparam int ITAG_W = 32 - IIDX_W - IBLK_W - 2;
  localparam int SETS   = 1 << IIDX_W;
  localparam int WPB    = 1 << IBLK_W;
  localparam int CNT_W  = cnt_width(IBLK_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WPB - 1);

  icache_state_t     state, next_state;
  logic [ITAG_W-1:0] req_tag, fill_tag;
  logic [IIDX_W-1:0] req_idx, fill_idx;
  logic [CNT_W-1:0]  req_blk, cnt;
  logic              victim, pick_victim, hit_way, match;
  logic [SETS-1:0]   lru;
  logic [31:0]       hit_cnt, miss_cnt;
  logic [WAYS-1:0]   way_hit, way_valid;
  word_t             way_word [WAYS];
  logic              start_fill, fill_accept, fill_last;
  logic              unused_addr_bits;

  // Fetch address split; byte offset bits carry no information for fetch.
  assign unused_addr_bits = ^imemaddr[1:0];
  assign req_tag = ITAG_W'(imemaddr >> (IIDX_W + IBLK_W + 2));
  assign req_idx = IIDX_W'(imemaddr >> (IBLK_W + 2));
  assign req_blk = (IBLK_W == 0) ? '0 : CNT_W'(imemaddr >> 2);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_assoc_fill_way #(
      .IIDX_W(IIDX_W),
      .IBLK_W(IBLK_W),
      .ITAG_W(ITAG_W),
      .CNT_W (CNT_W)
    ) u_way (
      .clk       (CLK),
      .rst       (RST),
      .flush     (flush),
      .rd_idx    (req_idx),
      .rd_tag    (req_tag),
      .rd_blk    (req_blk),
      .hit       (way_hit[w]),
      .valid     (way_valid[w]),
      .rd_word   (way_word[w]),
      .wr_en     (fill_accept && (victim == 1'(w))),
      .wr_idx    (fill_idx),
      .wr_blk    (cnt),
      .wr_data   (iload),
      .commit    (fill_last && (victim == 1'(w))),
      .commit_tag(fill_tag)
    );
  end

  // Hit way and replacement choice: an empty way first (way 0 preferred),
  // otherwise the way the set's LRU bit points at.
  always_comb begin
    match       = |way_hit;
    hit_way     = 1'b0;
    pick_victim = 1'b0;
    if (WAYS > 1) begin
      hit_way = way_hit[WAYS-1];
      if (!way_valid[0])           pick_victim = 1'b0;
      else if (!way_valid[WAYS-1]) pick_victim = 1'b1;
      else                         pick_victim = lru[req_idx];
    end
  end

  // Controller next state and outputs; flush overrides hits, new misses and
  // the final fill beat.
  always_comb begin
    next_state  = state;
    start_fill  = 1'b0;
    fill_accept = 1'b0;
    fill_last   = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    case (state)
      IDLE: begin
        ihit       = imemREN && match && !flush;
        start_fill = imemREN && !match && !flush;
        if (ihit) imemload = way_word[hit_way];
        if (start_fill) next_state = FILL;
      end
      FILL: begin
        iREN        = 1'b1;
        iaddr       = {fill_tag, fill_idx, {(IBLK_W + 2){1'b0}}} | (32'(cnt) << 2);
        fill_accept = !iwait && !flush;
        fill_last   = fill_accept && (cnt == LAST_CNT);
        if (flush || fill_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Fill context: line being fetched, target way and word counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_tag <= '0;
      fill_idx <= '0;
      victim   <= 1'b0;
      cnt      <= '0;
    end else if (start_fill) begin
      fill_tag <= req_tag;
      fill_idx <= req_idx;
      victim   <= pick_victim;
      cnt      <= '0;
    end else if (fill_accept) begin
      cnt <= fill_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // LRU bits: point away from the way just used (hit or freshly filled).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            lru <= '0;
    else if (flush)     lru <= '0;
    else if (ihit)      lru[req_idx] <= ~hit_way;
    else if (fill_last) lru[fill_idx] <= ~victim;
  end

  // Performance counters, free-running with wrap-around.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ihit)       hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
  assign fsm_state  = state;

endmodule

// File: doc/icache_assoc_fill.md
Name: icache_assoc_fill

Overview:
- Parametrised successor to the single-word direct-mapped icache.
- Configurable set count, words per block and way count (1 or 2), with LRU replacement.
- Sequential multi-word line fill FSM, single-cycle flush and hit/miss performance counters.
- Sits between the datapath fetch port and the memory controller instruction port.

Parameters:
- IIDX_W, 4, set-index width; SETS = 2**IIDX_W.
- IBLK_W, 1, block-offset width; WPB = 2**IBLK_W words per line (0 is legal: one word per line).
- WAYS, 2, associativity; legal values 1 or 2.
- ITAG_W, 32-IIDX_W-IBLK_W-2, derived tag width; never overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  combinational; fetch hit this cycle.
- imemload  out  32  combinational; hit word, 0 when ihit=0.
- flush  in  1  invalidate all lines.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; word in iload is valid when iwait=0 and iREN=1.
- iload  in  32  memory read data.
- hit_count  out  32  hits since reset; wraps.
- miss_count  out  32  misses since reset; wraps.

Behaviour:
- Reset and clock:
  - One clock. Reset is asynchronous and active-high.
  - Reset clears all valid bits, LRU bits, fill counter and both counters. FSM goes to IDLE.
  - Post-reset outputs: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
- Address split: {tag[ITAG_W], idx[IIDX_W], blk[IBLK_W], byt[2]}.
- Frame contents per way: valid, tag, WPB data words. One LRU bit per set (unused when WAYS=1).
- IDLE state:
  - ihit = imemREN & way match (valid & tag equal).
  - imemload = the matching word.
  - On a hit, hit_count increments and the set's LRU bit points away from the hit way.
  - On imemREN with no match: latch tag/idx, victim = invalid way if any (way0 preferred), else LRU way. miss_count increments once, cnt=0, go to FILL.
- FILL state:
  - iREN=1, iaddr={latched tag, idx, cnt, 2'b00}.
  - On each cycle with iwait=0: write iload into victim word cnt, cnt++.
  - On the last word (cnt==WPB-1 accepted): set victim valid and tag, point LRU away from the victim, go to IDLE.
  - The following cycle re-compares and hits.
  - ihit=0 throughout FILL. Latency = WPB accepted words + 1 cycle.
- Request changes during FILL:
  - If imemREN drops or imemaddr changes, the fill still completes for the latched line.
  - The new address is compared afterwards.
- Flush:
  - In IDLE: clears all valid and LRU bits at the edge; ihit=0 that cycle. Counters unaffected.
  - During FILL: aborts the fill. iREN drops the next cycle, the line is not validated, FSM returns to IDLE.
  - Flush wins over a simultaneous final fill word.
- Counters use 32-bit wrap-around; 0xFFFFFFFF+1 = 0.
- Reset mid-FILL: immediate return to IDLE, iREN=0.

Decomposition:
- Add to cpu_types_pkg:
  - icache_state_t enum {IDLE, FILL}.
  - Parametrised icache frame struct (valid, tag, word_t [WPB-1:0]).
  - Address format struct icachef_blk_t with blkoff.
- One sub-module, icache_way: SETS×frame storage, tag compare, word select, fill write port. Instantiated WAYS times.
- Top level holds the FSM, LRU, victim select and counters.

Test Plan:
- Defaults; reset; fetch 0x00000040 (idx 8, blk 0), iwait high 2 cycles per word, iload 0xAAAA0001 then 0xAAAA0002 -> iaddr 0x40 then 0x44, miss_count=1; next cycle ihit=1, imemload=0xAAAA0001; fetch 0x44 -> hit 0xAAAA0002, hit_count=2.
- Fill 0x40, 0x840 and 0x1040 (same set, three tags) -> third fill evicts the way holding 0x40 (LRU). Refetch 0x840 hits; refetch 0x40 misses.
- flush asserted mid-FILL after the first word -> iREN=0 next cycle; refetch 0x40 misses and refills both words.
- imemaddr changes to 0x80 mid-fill of 0x40 -> fill of 0x40 completes, then 0x80 misses and fills; miss_count=2.
- Force hit_count=0xFFFFFFFF via hits, one more hit -> 0.
- RST pulsed asynchronously mid-FILL -> iREN=0 immediately, all counters 0, prior lines miss.
